div_iter_unit: RTL
==================

// Module: div_iter_unit
// PURPOSE
//  Multi-cycle 32-bit radix-2 restoring divider. It answers the EX-stage start/ready division handshake.
//  EX drives the operands and holds start_i high while ready_o is low, stalling the pipeline.
//  This block returns {remainder, quotient} for DIV/DIVU, destined for HI/LO.
// PARAMETERS
//  WIDTH     32  operand width; the HI/LO datapath fixes it at 32, no other value is supported
//  CNT_W     6   iteration counter width; must hold WIDTH
// PORTS
//  clk           in   1   core clock; all state changes on the rising edge
//  resetn        in   1   asynchronous, active-low reset
//  signed_div_i  in   1   1 = DIV (signed), 0 = DIVU (unsigned)
//  opdata1_i     in   32  dividend
//  opdata2_i     in   32  divisor
//  start_i       in   1   `DivStart request; held by the requester until ready_o is seen
//  annul_i       in   1   abort the current operation (flush)
//  result_o      out  64  {remainder[63:32], quotient[31:0]}
//  ready_o       out  1   `DivResultReady; result_o is valid while this is high
// BEHAVIOUR
//  Reset: resetn=0 asynchronously forces state=IDLE, counter=0, ready_o=0, result_o=`ZeroWord x2.
//   This applies at any time, including mid-operation.
//  States: IDLE, DIVZERO, BUSY, DONE. Encodings are in the shared header.
//  IDLE
//   - start_i=1, annul_i=0, opdata2_i!=0: latch operand magnitudes, dividend sign, divisor sign
//     and signed_div_i; counter=0; go to BUSY.
//   - start_i=1, annul_i=0, opdata2_i==0: go to DIVZERO.
//   - Otherwise stay in IDLE. annul_i in IDLE blocks a start on that cycle.
//  Magnitudes: if signed_div_i=1, a negative operand is replaced by its two's complement.
//   Otherwise the operand is taken as-is.
//  BUSY: one restoring step per cycle on a 65-bit partial remainder.
//   - Shift left 1, trial-subtract {1'b0, divisor}.
//   - If no borrow, keep the difference and shift in quotient bit 1; else shift in 0.
//   - counter increments each step. After the step with counter==31, go to DONE.
//  Sign fix-up is applied on the way into DONE, only for signed operations:
//   - quotient is negated if the operand signs differ.
//   - remainder takes the dividend's sign.
//  -2^31 / -1 wraps naturally: quotient 0x80000000, remainder 0. No trap is raised.
//  DIVZERO: result_o=0 (both halves); go to DONE on the next edge.
//  DONE
//   - ready_o=1; result_o is held stable.
//   - Stay while start_i=1.
//   - On start_i=0: go to IDLE, ready_o=0 on that edge; result_o keeps its last value.
//  Latency, counting the edge that samples start as edge 0:
//   - ready_o is high after edge 33 for a nonzero divisor, after edge 2 for a zero divisor.
//  start_i dropping during BUSY or DIVZERO is ignored; only annul_i cancels.
//  annul_i=1 in BUSY, DIVZERO or DONE: go to IDLE on the next edge, ready_o=0, no result is
//   produced. annul_i wins over every other condition on the same edge.
//  Operand inputs may change after the start edge without effect, because they were latched.
//  ready_o and state are registered only. There is no combinational path from inputs to outputs.
// CONFIGURATION
//  DIV_EARLY_OUT_EN: defines the early-out path.
//   - Defined: in IDLE, a start with nonzero divisor and |dividend| < |divisor| (magnitude
//     compare) goes to DONE on edge 1 with quotient=0 and remainder=original opdata1_i.
//     No fix-up is needed. ready_o is high after edge 1.
//   - Undefined: such operands take the full 33-edge path. The results are bit-identical either way.
// STRUCTURE
//  Shared header lib/defines.vh holds:
//   - the existing `DivStart/`DivStop, `DivResultReady/`DivResultNotReady and `ZeroWord.
//   - new `DivFree, `DivByZero, `DivOn, `DivEnd (2-bit state codes) and `DivIterCnt (6'd32).
//  One combinational sub-module, div_step:
//   - inputs: 65-bit partial remainder and 32-bit divisor.
//   - outputs: next partial remainder and the quotient bit.
//  Abs/negate logic and the FSM stay in div_iter_unit.
// TESTING
//  1. DIVU 100 / 7: ready_o after edge 33, result_o = {32'd2, 32'd14}. Drop start_i: ready_o=0 next edge.
//  2. DIV -7 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / -2: quotient 0xFFFFFFFD, remainder 1.
//  3. DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. DIVU of the same operands:
//     quotient 0, remainder 0x80000000.
//  4. Divisor 0, dividend 0x1234: ready_o after edge 2, result_o = 64'h0. Hold start_i 5 cycles:
//     the result stays stable.
//  5. Pulse annul_i at BUSY cycle 10: IDLE next edge, ready_o never rises. A fresh DIVU 9/3 then
//     completes with {0, 3}.
//  6. Drive resetn=0 between edges mid-BUSY: ready_o=0 and result_o=0 immediately.
//     With DIV_EARLY_OUT_EN: DIVU 3/10 gives ready after edge 1, {32'd3, 32'd0}.

Source files
------------

// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the iterative divider: handshake levels, FSM state codes,
// iteration count and a magnitude helper.
// Provides:
//   DivStart/DivStop, DivResultReady/DivResultNotReady, ZeroWord
//   div_state_e : DivFree, DivByZero, DivOn, DivEnd (2-bit codes)
//   DivIterCnt  : number of restoring steps per operation (6'd32)
//   abs_val()   : two's-complement magnitude of a signed operand
package div_iter_unit_pkg;

    localparam int unsigned Width = 32;
    localparam int unsigned CntW  = 6;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [Width-1:0] ZeroWord    = 32'h0000_0000;
    localparam logic [CntW-1:0]  DivIterCnt  = 6'd32;
    localparam logic [CntW-1:0]  DivLastStep = DivIterCnt - 6'd1;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Magnitude of v; only negated when the operation is signed and v is negative.
    function automatic logic [Width-1:0] abs_val(input logic [Width-1:0] v,
                                                 input logic             is_signed);
        return (is_signed && v[Width-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   pr_i      : 65-bit partial remainder {remainder, dividend/quotient bits}
//   divisor_i : 32-bit divisor magnitude
//   pr_o      : partial remainder after shift and conditional subtract
//   q_bit_o   : quotient bit produced by this step (1 = subtract succeeded)
module div_step
    import div_iter_unit_pkg::*;
(
    input  logic [2*Width:0]   pr_i,
    input  logic [Width-1:0]   divisor_i,
    output logic [2*Width:0]   pr_o,
    output logic               q_bit_o
);

    logic [2*Width+1:0] shifted;
    logic [Width+1:0]   diff;

    always_comb begin
        shifted = {pr_i, 1'b0};
        // Trial subtract on the upper part; diff MSB is the borrow.
        diff    = shifted[2*Width+1:Width] - {2'b00, divisor_i};
        q_bit_o = ~diff[Width+1];
        pr_o    = shifted[2*Width:0];
        if (q_bit_o) begin
            pr_o[2*Width:Width] = diff[Width:0];
            pr_o[0]             = 1'b1;
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for the EX-stage start/ready handshake.
// Returns {remainder, quotient} for DIV (signed) and DIVU (unsigned).
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   signed_div_i : 1 = DIV, 0 = DIVU
//   opdata1_i    : dividend          opdata2_i : divisor
//   start_i      : request, held until ready_o is seen
//   annul_i      : abort the current operation
//   result_o     : {remainder[63:32], quotient[31:0]}, valid while ready_o is high
//   ready_o      : result ready (registered)
// Configuration macro DIV_EARLY_OUT_EN: when defined, |dividend| < |divisor| finishes
// straight away with quotient 0 and remainder = original dividend.
module div_iter_unit
    import div_iter_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 signed_div_i,
    input  logic [Width-1:0]     opdata1_i,
    input  logic [Width-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*Width-1:0]   result_o,
    output logic                 ready_o
);

    div_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*Width:0]    pr_q, pr_d;
    logic [Width-1:0]    dvs_q, dvs_d;
    logic                dvd_neg_q, dvd_neg_d;
    logic                dvs_neg_q, dvs_neg_d;
    logic                signed_q, signed_d;
    logic [2*Width-1:0]  result_q, result_d;
    logic                ready_q, ready_d;

    logic [Width-1:0]    dvd_mag, dvs_mag;
    logic [2*Width:0]    step_pr;
    logic                step_q_bit;
    logic [Width-1:0]    quo_raw, rem_raw, quo_fix, rem_fix;
    logic                early_out;

    assign dvd_mag = abs_val(opdata1_i, signed_div_i);
    assign dvs_mag = abs_val(opdata2_i, signed_div_i);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (dvd_mag < dvs_mag);
`else
    assign early_out = 1'b0;
`endif

    div_step u_div_step (
        .pr_i      (pr_q),
        .divisor_i (dvs_q),
        .pr_o      (step_pr),
        .q_bit_o   (step_q_bit)
    );

    // Final-step result with sign fix-up (signed only).
    assign quo_raw = {step_pr[Width-1:1], step_q_bit};
    assign rem_raw = step_pr[2*Width-1:Width];
    assign quo_fix = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (~quo_raw + 32'd1) : quo_raw;
    assign rem_fix = (signed_q && dvd_neg_q) ? (~rem_raw + 32'd1) : rem_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        dvs_d     = dvs_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        signed_d  = signed_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == ZeroWord) begin
                        state_d = DivByZero;
                    end else if (early_out) begin
                        state_d  = DivEnd;
                        result_d = {opdata1_i, ZeroWord};
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        pr_d      = {{(Width+1){1'b0}}, dvd_mag};
                        dvs_d     = dvs_mag;
                        dvd_neg_d = signed_div_i & opdata1_i[Width-1];
                        dvs_neg_d = signed_div_i & opdata2_i[Width-1];
                        signed_d  = signed_div_i;
                    end
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = {ZeroWord, ZeroWord};
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    pr_d  = step_pr;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == DivLastStep) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            DivEnd: begin
                // ready rises one cycle after entering DONE; leaving requires it seen.
                if (annul_i) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end else if (ready_q == DivResultNotReady) begin
                    ready_d = DivResultReady;
                end else if (start_i == DivStop) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            pr_q      <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            signed_q  <= 1'b0;
            result_q  <= {ZeroWord, ZeroWord};
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            dvs_q     <= dvs_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            signed_q  <= signed_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
